image_rom_arbiter: RTL and testbench
====================================

IMAGE_ROM_ARBITER -- requirements
Module: image_rom_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: pclk input clocks all state; rst input resets asynchronously, active-high.
REQ-002 Parameters SHALL be, one per line:
- ADDR_W, 20, ROM address width.
- DATA_W, 12, ROM pixel width (RGB 4:4:4).
- ROM_LAT, 1, ROM read latency in pclk cycles, range 1..4.
REQ-003 Ports SHALL be, one per line, as name, direction, width, meaning:
- pclk  in  1  pixel clock.
- rst  in  1  asynchronous active-high reset.
- req[2:0]  in  3  read request per requester: 0 = background, 1 = blob A, 2 = blob B.
- addr0/addr1/addr2  in  ADDR_W each  requester read address.
- gnt[2:0]  out  3  one-hot grant, combinational, same cycle as req.
- rd_valid[2:0]  out  3  one-hot read-data strobe.
- rd_data  out  DATA_W  read data, shared by all requesters.
- rom_addr  out  ADDR_W  registered address to the image ROM.
- rom_rgb  in  DATA_W  ROM read data.

Function
REQ-004 gnt SHALL be zero or one-hot; gnt[i] SHALL be 1 only if req[i] is 1.
REQ-005 If any req bit is 1, exactly one gnt bit SHALL be 1 that cycle; if req == 0, gnt SHALL be 0.
REQ-006 On the pclk edge ending a grant cycle N, rom_addr SHALL load the granted requester's address; with no grant, rom_addr SHALL hold its value.
REQ-007 A tag pipeline of depth ROM_LAT+1 SHALL carry {valid, requester index} for each grant.
REQ-008 For a grant to requester i in cycle N, rd_valid[i] SHALL be 1 in cycle N+1+ROM_LAT only, and rd_data SHALL equal rom_rgb in that cycle.
REQ-009 rd_data SHALL be rom_rgb passed through combinationally; it is meaningful only while rd_valid != 0.
REQ-010 Back-to-back grants SHALL be sustained at one per cycle with no bubbles; throughput SHALL be 1 read/cycle.
REQ-011 A pointer last_gnt (2 bits, values 0..2) SHALL record the most recent granted index; it SHALL update only on cycles with a grant.
REQ-012 Arbitration order SHALL be governed by REQ-020.
REQ-013 A requester that drops req before being granted SHALL receive no grant and no rd_valid; no request queuing SHALL exist.
REQ-014 A requester SHALL NOT receive a second rd_valid for a single grant; outstanding reads per requester are unlimited (one per grant).

Reset
REQ-015 While rst = 1, and on deassertion: rom_addr = 0, last_gnt = 2, all tag valid bits = 0, rd_valid = 0.
REQ-016 While rst = 1, gnt SHALL be 0.
REQ-017 Reset asserted mid-operation SHALL discard all in-flight reads; no rd_valid SHALL appear for grants issued before reset.
REQ-018 The first grant after reset SHALL follow arbitration from last_gnt = 2, so requester 0 wins if requesting.

Configuration
REQ-019 The macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy at compile time.
REQ-020 With ARB_ROUND_ROBIN_EN defined, priority SHALL rotate: search starts at index (last_gnt+1) mod 3 and wraps. A continuously requesting requester SHALL be granted within 3 cycles.
REQ-021 Without ARB_ROUND_ROBIN_EN, priority SHALL be fixed, 0 > 1 > 2. last_gnt SHALL still be maintained but SHALL NOT affect gnt.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single requester: req=3'b001, addr0=20'h00010, ROM_LAT=1. Response: gnt=001 in cycle N; rom_addr=20'h00010 in cycle N+1; rd_valid=001 and rd_data equals ROM[0x10] in cycle N+2.
- Round robin (ARB_ROUND_ROBIN_EN defined): req=3'b111 held for 6 cycles after reset. Response: gnt sequence 001,010,100,001,010,100; rd_valid sequence identical, delayed by 2 cycles.
- Fixed priority (ARB_ROUND_ROBIN_EN undefined): req=3'b110 held for 4 cycles. Response: gnt=010 every cycle; requester 2 never granted.
- Idle hold: grant addr1=20'h0ABCD, then req=0 for 5 cycles. Response: rom_addr stays 20'h0ABCD; gnt=0; rd_valid=0 after the drain.
- Reset mid-flight: grant in cycle N, rst pulsed in cycle N+1. Response: no rd_valid in cycle N+2; rom_addr=0; next grant with req=111 goes to 0.
- Latency parameter: ROM_LAT=3, single grant to requester 2 in cycle N. Response: rd_valid=100 in cycle N+4 only.

Source files
------------

// File: rtl/image_rom_arbiter.sv
// ---------------------------------------------------------------------------
// image_rom_arbiter
// Three requesters (0 = background, 1 = blob A, 2 = blob B) share one image
// ROM port. A combinational arbiter picks one requester per pclk cycle. The
// winning address is registered onto rom_addr. A tag pipeline of depth
// ROM_LAT+1 then routes the ROM data back as a one-hot rd_valid strobe to the
// owner of each read.
//
// Compile-time option:
//   ARB_ROUND_ROBIN_EN  defined   -> rotating priority starting after last_gnt
//                       undefined -> fixed priority 0 > 1 > 2
// ---------------------------------------------------------------------------
module image_rom_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 1
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic [2:0]        gnt,
  output logic [2:0]        rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rgb
);

  // Pick the first requesting index in the order a, b, c; one-hot or zero.
  function automatic logic [2:0] f_pick(input logic [2:0] i_req,
                                        input logic [1:0] i_a,
                                        input logic [1:0] i_b,
                                        input logic [1:0] i_c);
    logic [2:0] v_g;
    v_g = 3'b000;
    if (i_req[i_a]) begin
      v_g[i_a] = 1'b1;
    end else if (i_req[i_b]) begin
      v_g[i_b] = 1'b1;
    end else if (i_req[i_c]) begin
      v_g[i_c] = 1'b1;
    end else begin
      v_g = 3'b000;
    end
    return v_g;
  endfunction

  // Most recently granted index; 2 after reset so requester 0 is searched first.
  logic [1:0]              r_last_gnt;
  // Tag pipeline: stage k holds the grant issued k+1 cycles earlier.
  logic [ROM_LAT:0]        r_tag_vld;
  logic [ROM_LAT:0][1:0]   r_tag_idx;
  logic [ADDR_W-1:0]       r_rom_addr;

  logic [2:0]              w_gnt;
  logic                    w_gnt_any;
  logic [1:0]              w_gnt_idx;
  logic [ADDR_W-1:0]       w_gnt_addr;
  logic [2:0]              w_rd_valid;

  // Arbitration: grant is suppressed entirely while reset is held.
  always_comb begin
    w_gnt = 3'b000;
    if (rst) begin
      w_gnt = 3'b000;
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      case (r_last_gnt)
        2'd0:    w_gnt = f_pick(req, 2'd1, 2'd2, 2'd0);
        2'd1:    w_gnt = f_pick(req, 2'd2, 2'd0, 2'd1);
        default: w_gnt = f_pick(req, 2'd0, 2'd1, 2'd2);
      endcase
`else
      w_gnt = f_pick(req, 2'd0, 2'd1, 2'd2);
`endif
    end
  end

  // Encode the one-hot grant and select the winning address.
  always_comb begin
    w_gnt_any  = 1'b0;
    w_gnt_idx  = 2'd0;
    w_gnt_addr = r_rom_addr;
    case (w_gnt)
      3'b001: begin
        w_gnt_any  = 1'b1;
        w_gnt_idx  = 2'd0;
        w_gnt_addr = addr0;
      end
      3'b010: begin
        w_gnt_any  = 1'b1;
        w_gnt_idx  = 2'd1;
        w_gnt_addr = addr1;
      end
      3'b100: begin
        w_gnt_any  = 1'b1;
        w_gnt_idx  = 2'd2;
        w_gnt_addr = addr2;
      end
      default: begin
        w_gnt_any  = 1'b0;
        w_gnt_idx  = 2'd0;
        w_gnt_addr = r_rom_addr;
      end
    endcase
  end

  // ROM address register and last-grant pointer; both hold when idle.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_rom_addr <= {ADDR_W{1'b0}};
      r_last_gnt <= 2'd2;
    end else if (w_gnt_any) begin
      r_rom_addr <= w_gnt_addr;
      r_last_gnt <= w_gnt_idx;
    end else begin
      r_rom_addr <= r_rom_addr;
      r_last_gnt <= r_last_gnt;
    end
  end

  // Tag pipeline; reset drops every in-flight read.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_tag_vld <= '0;
      r_tag_idx <= '0;
    end else begin
      r_tag_vld[0] <= w_gnt_any;
      r_tag_idx[0] <= w_gnt_idx;
      for (int k = 1; k <= ROM_LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_idx[k] <= r_tag_idx[k-1];
      end
    end
  end

  // Decode the last tag stage into the one-hot data strobe.
  always_comb begin
    w_rd_valid = 3'b000;
    if (r_tag_vld[ROM_LAT]) begin
      case (r_tag_idx[ROM_LAT])
        2'd0:    w_rd_valid = 3'b001;
        2'd1:    w_rd_valid = 3'b010;
        2'd2:    w_rd_valid = 3'b100;
        default: w_rd_valid = 3'b000;
      endcase
    end else begin
      w_rd_valid = 3'b000;
    end
  end

  assign gnt      = w_gnt;
  assign rd_valid = w_rd_valid;
  assign rd_data  = rom_rgb;
  assign rom_addr = r_rom_addr;

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Directed bench for image_rom_arbiter: one instance with ROM_LAT=1 and one
// with ROM_LAT=3, each fed by its own behavioural ROM (data = addr[11:0]^5A5).
module tb_image_rom_arbiter;

  logic        pclk;
  logic        rst;
  logic [2:0]  req,   req_b;
  logic [19:0] addr0, addr1, addr2;
  logic [19:0] addr0_b, addr1_b, addr2_b;
  logic [2:0]  gnt,   gnt_b;
  logic [2:0]  rd_valid, rd_valid_b;
  logic [11:0] rd_data, rd_data_b;
  logic [19:0] rom_addr, rom_addr_b;
  logic [11:0] rom_rgb, rom_rgb_b;
  logic [11:0] rom_s1_b, rom_s2_b;

  int n_vec;
  int n_err;

  logic [2:0] exp_a [6];
  logic [2:0] exp_p [4];

  image_rom_arbiter #(.ADDR_W(20), .DATA_W(12), .ROM_LAT(1)) u_dut (
    .pclk(pclk), .rst(rst), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb)
  );

  image_rom_arbiter #(.ADDR_W(20), .DATA_W(12), .ROM_LAT(3)) u_dut_lat3 (
    .pclk(pclk), .rst(rst), .req(req_b),
    .addr0(addr0_b), .addr1(addr1_b), .addr2(addr2_b),
    .gnt(gnt_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
    .rom_addr(rom_addr_b), .rom_rgb(rom_rgb_b)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // One-cycle ROM for the ROM_LAT=1 instance.
  always @(posedge pclk) rom_rgb <= rom_addr[11:0] ^ 12'h5A5;

  // Three-cycle ROM for the ROM_LAT=3 instance.
  always @(posedge pclk) begin
    rom_s1_b  <= rom_addr_b[11:0] ^ 12'h5A5;
    rom_s2_b  <= rom_s1_b;
    rom_rgb_b <= rom_s2_b;
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    req = 3'b000;
    tick;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_a = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_p = '{3'b010, 3'b100, 3'b010, 3'b100};
`else
    exp_a = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    exp_p = '{3'b010, 3'b010, 3'b010, 3'b010};
`endif
    rst = 1'b1;
    req = 3'b000; addr0 = 20'h0; addr1 = 20'h0; addr2 = 20'h0;
    req_b = 3'b000; addr0_b = 20'h0; addr1_b = 20'h0; addr2_b = 20'h0;

    // Reset state: gnt gated even with every requester active.
    tick;
    tick;
    req = 3'b111;
    #1;
    chk_eq("rst_gnt", {29'd0, gnt}, 32'h0);
    chk_eq("rst_rom_addr", {12'd0, rom_addr}, 32'h0);
    chk_eq("rst_rd_valid", {29'd0, rd_valid}, 32'h0);
    chk_eq("rst_rd_valid_lat3", {29'd0, rd_valid_b}, 32'h0);
    req = 3'b000;
    rst = 1'b0;

    // Single requester.
    tick;
    req = 3'b001; addr0 = 20'h00010;
    #1;
    chk_eq("single_gnt", {29'd0, gnt}, 32'h1);
    tick;
    req = 3'b000;
    #1;
    chk_eq("single_rom_addr", {12'd0, rom_addr}, 32'h10);
    chk_eq("single_rdv_early", {29'd0, rd_valid}, 32'h0);
    tick;
    chk_eq("single_rdv", {29'd0, rd_valid}, 32'h1);
    chk_eq("single_rd_data", {20'd0, rd_data}, 32'h5B5);
    tick;
    chk_eq("single_rdv_once", {29'd0, rd_valid}, 32'h0);

    // All three requesting for six cycles from a fresh reset.
    apply_reset;
    for (int i = 0; i < 8; i++) begin
      tick;
      req = (i < 6) ? 3'b111 : 3'b000;
      #1;
      if (i < 6) chk_eq($sformatf("all_gnt%0d", i), {29'd0, gnt}, {29'd0, exp_a[i]});
      if (i >= 2) chk_eq($sformatf("all_rdv%0d", i), {29'd0, rd_valid}, {29'd0, exp_a[i-2]});
    end

    // Requesters 1 and 2 only, from a fresh reset.
    apply_reset;
    for (int i = 0; i < 6; i++) begin
      tick;
      req = (i < 4) ? 3'b110 : 3'b000;
      #1;
      if (i < 4) chk_eq($sformatf("r12_gnt%0d", i), {29'd0, gnt}, {29'd0, exp_p[i]});
      if (i >= 2) chk_eq($sformatf("r12_rdv%0d", i), {29'd0, rd_valid}, {29'd0, exp_p[i-2]});
    end

    // Idle hold after a single grant to requester 1.
    tick;
    req = 3'b010; addr1 = 20'h0ABCD;
    #1;
    chk_eq("idle_gnt1", {29'd0, gnt}, 32'h2);
    for (int i = 0; i < 5; i++) begin
      tick;
      req = 3'b000;
      #1;
      chk_eq($sformatf("idle_gnt%0d", i), {29'd0, gnt}, 32'h0);
      chk_eq($sformatf("idle_addr%0d", i), {12'd0, rom_addr}, 32'h0ABCD);
      chk_eq($sformatf("idle_rdv%0d", i), {29'd0, rd_valid}, (i == 1) ? 32'h2 : 32'h0);
    end

    // Reset pulse one cycle after a grant.
    tick;
    req = 3'b001; addr0 = 20'h00123;
    #1;
    chk_eq("mid_gnt", {29'd0, gnt}, 32'h1);
    tick;
    req = 3'b000;
    rst = 1'b1;
    #1;
    chk_eq("mid_rst_addr", {12'd0, rom_addr}, 32'h0);
    chk_eq("mid_rst_gnt", {29'd0, gnt}, 32'h0);
    #2;
    rst = 1'b0;
    tick;
    chk_eq("mid_no_rdv", {29'd0, rd_valid}, 32'h0);
    chk_eq("mid_addr0", {12'd0, rom_addr}, 32'h0);
    req = 3'b111; addr0 = 20'h00044;
    #1;
    chk_eq("mid_next_gnt", {29'd0, gnt}, 32'h1);
    tick;
    req = 3'b000;
    #1;
    chk_eq("mid_next_rdv_early", {29'd0, rd_valid}, 32'h0);
    tick;
    chk_eq("mid_next_rdv", {29'd0, rd_valid}, 32'h1);
    chk_eq("mid_next_data", {20'd0, rd_data}, 32'h5E1);

    // ROM_LAT=3 instance: grant to requester 2.
    tick;
    req_b = 3'b100; addr2_b = 20'h00777;
    #1;
    chk_eq("lat3_gnt", {29'd0, gnt_b}, 32'h4);
    for (int i = 1; i <= 5; i++) begin
      tick;
      req_b = 3'b000;
      #1;
      chk_eq($sformatf("lat3_rdv_n%0d", i), {29'd0, rd_valid_b}, (i == 4) ? 32'h4 : 32'h0);
      if (i == 4) chk_eq("lat3_data", {20'd0, rd_data_b}, 32'h2D2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
